// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage sequencer: owns the sample RAM, walks log2(N) stages issuing butterfly commands.
// States: IDLE wait frame | CHECK validate N | ISSUE send butterflies | DRAIN wait write-backs | DONE results ready
module fft_stage_sequencer #(
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_DATA_LOADED,
  input  logic [11:0]           i_SAMPLES_NUMBER,
  input  logic                  i_RESULT_READ,
  input  logic                  i_BF_READY,
  input  logic                  i_BF_DONE,
  output logic                  o_BF_VALID,
  output logic [ADDR_WIDTH-1:0] o_ADDR_A,
  output logic [ADDR_WIDTH-1:0] o_ADDR_B,
  output logic [ADDR_WIDTH-2:0] o_TWIDDLE_IDX,
  output logic [3:0]            o_STAGE,
  output logic                  o_RAM_OWNER,
  output logic                  o_BUSY,
  output logic                  o_CALC_END,
  output logic                  o_ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [2:0]            state_q, state_d;
  logic [11:0]           n_q, n_d;
  logic [3:0]            l_q, l_d;
  logic [3:0]            s_q, s_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [3:0]            out_q, out_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ADDR_WIDTH-2:0] tw_q, tw_d;
  logic                  owner_q, owner_d, busy_q, busy_d, end_q, end_d, err_q, err_d;

  logic                  xfer, done_eff, n_ok;
  logic [3:0]            n_log2, cmd_s;
  logic [ADDR_WIDTH-1:0] k_last, cmd_k, half, j, grp, cmd_a, cmd_b;
  logic [ADDR_WIDTH-2:0] cmd_tw;

  assign xfer     = (state_q == S_ISSUE) && valid_q && i_BF_READY;
  assign done_eff = i_BF_DONE && (out_q != 4'd0);
  assign out_d    = out_q + {3'b000, xfer} - {3'b000, done_eff};
  assign n_ok     = (n_q >= 12'd2) && (n_q <= 12'd2048) && ((n_q & (n_q - 12'd1)) == 12'd0);
  assign k_last   = ADDR_WIDTH'({1'b0, n_q[11:1]} - 12'd1);

  always_comb begin
    n_log2 = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (n_q[i]) n_log2 = 4'(i);
    end
  end

  // Next command: first of the following stage when leaving DRAIN, else k or k+1 of this stage.
  assign cmd_s = (state_q == S_DRAIN) ? s_q + 4'd1 : s_q;
  assign cmd_k = (state_q == S_DRAIN) ? '0 : (xfer ? k_q + 1'b1 : k_q);

  always_comb begin
    half   = ADDR_WIDTH'(1) << cmd_s;
    j      = cmd_k & (half - 1'b1);
    grp    = cmd_k >> cmd_s;
    cmd_a  = (grp << (cmd_s + 4'd1)) | j;
    cmd_b  = cmd_a | half;
    cmd_tw = (ADDR_WIDTH-1)'(j << (l_q - 4'd1 - cmd_s));
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    l_d     = l_q;
    s_d     = s_q;
    k_d     = k_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    tw_d    = tw_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    end_d   = end_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        owner_d = 1'b0;
        if (i_DATA_LOADED) begin
          n_d     = i_SAMPLES_NUMBER;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (n_ok) begin
          l_d     = n_log2;
          s_d     = 4'd0;
          k_d     = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          end_d   = 1'b0;
          state_d = S_ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        owner_d = 1'b1;
        if (xfer && (k_q == k_last)) begin
          valid_d = 1'b0;
          state_d = S_DRAIN;
        end else if (!valid_q || xfer) begin
          // A presented command is only withdrawn by a transfer, so the cap never drops it mid-offer.
          k_d     = cmd_k;
          a_d     = cmd_a;
          b_d     = cmd_b;
          tw_d    = cmd_tw;
          valid_d = (out_d != MAX_OUT);
        end
      end
      S_DRAIN: begin
        if (out_q == 4'd0) begin
          if (s_q == l_q - 4'd1) begin
            end_d   = 1'b1;
            busy_d  = 1'b0;
            owner_d = 1'b0;
            state_d = S_DONE;
          end else begin
            s_d     = cmd_s;
            k_d     = '0;
            a_d     = cmd_a;
            b_d     = cmd_b;
            tw_d    = cmd_tw;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (i_DATA_LOADED) begin
          n_d     = i_SAMPLES_NUMBER;
          end_d   = 1'b0;
          state_d = S_CHECK;
        end else if (i_RESULT_READ) begin
          end_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      l_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      l_q     <= l_d;
      s_q     <= s_d;
      k_q     <= k_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign o_BF_VALID    = valid_q;
  assign o_ADDR_A      = a_q;
  assign o_ADDR_B      = b_q;
  assign o_TWIDDLE_IDX = tw_q;
  assign o_STAGE       = s_q;
  assign o_RAM_OWNER   = owner_q;
  assign o_BUSY        = busy_q;
  assign o_CALC_END    = end_q;
  assign o_ERR         = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: expected butterfly lists come from the textbook span/base/j walk of a radix-2 FFT.
module tb_fft_stage_sequencer;
  localparam int AW   = 12;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst, loaded, rread, rdy, done;
  logic [11:0] nsamp;
  logic        o_valid, o_owner, o_busy, o_end, o_err;
  logic [AW-1:0] o_a, o_b;
  logic [AW-2:0] o_tw;
  logic [3:0]  o_stage;

  fft_stage_sequencer #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst(rst), .i_DATA_LOADED(loaded), .i_SAMPLES_NUMBER(nsamp),
    .i_RESULT_READ(rread), .i_BF_READY(rdy), .i_BF_DONE(done),
    .o_BF_VALID(o_valid), .o_ADDR_A(o_a), .o_ADDR_B(o_b), .o_TWIDDLE_IDX(o_tw),
    .o_STAGE(o_stage), .o_RAM_OWNER(o_owner), .o_BUSY(o_busy), .o_CALC_END(o_end), .o_ERR(o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] a;
    logic [11:0] b;
    logic [10:0] tw;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t cur, prev_cmd, exp_c;
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, dly = 1, rdy_mode = 0;
  int   due_q[$];
  int   out_m = 0, max_out = 0;
  bit   prev_stall = 0, de;
  logic [3:0] last_st = 4'd0;

  task automatic chk(input string nm, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Returns log2(N) and appends the run's commands in issue order; returns 0 and appends nothing for an invalid N.
  function automatic int build_model(input int n);
    int  l = 0;
    bit  ok = 0;
    for (int p = 2; p <= 2048; p *= 2) if (n == p) ok = 1;
    if (!ok) return 0;
    for (int span = 1; span < n; span *= 2) begin
      for (int base = 0; base < n; base += 2 * span) begin
        for (int jj = 0; jj < span; jj++) begin
          cmd_t c;
          c.st = 4'(l);
          c.a  = 12'(base + jj);
          c.b  = 12'(base + jj + span);
          c.tw = 11'(jj * (n / (2 * span)));
          exp_q.push_back(c);
        end
      end
      l++;
    end
    return l;
  endfunction

  always @(posedge clk) cyc++;

  // Butterfly unit stand-in: READY pattern plus DONE pulses dly edges after each acceptance.
  initial begin
    rdy = 1'b0;
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        due_q.delete();
        done = 1'b0;
        rdy = 1'b0;
      end else begin
        rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        done = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
          done = 1'b1;
          void'(due_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    cur = {o_stage, o_a, o_b, o_tw};
    if (rst) begin
      out_m = 0;
      prev_stall = 0;
      last_st = 4'd0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_cmd", cur, prev_cmd);
      end
      if (o_valid) chk("owner_when_valid", o_owner, 1);
      de = done && (out_m != 0);
      if (o_valid && rdy) begin
        if (cur.st != last_st && cur.st != 4'd0) chk("stage_after_drain", out_m, 0);
        last_st = cur.st;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cmd_unexpected: got stage %0d a %0d b %0d tw %0d, expected no command",
                   cur.st, cur.a, cur.b, cur.tw);
        end else begin
          exp_c = exp_q.pop_front();
          chk("cmd_stage", cur.st, exp_c.st);
          chk("cmd_a", cur.a, exp_c.a);
          chk("cmd_b", cur.b, exp_c.b);
          chk("cmd_tw", cur.tw, exp_c.tw);
        end
        due_q.push_back(cyc + 1 + dly);
      end
      out_m = out_m + ((o_valid && rdy) ? 1 : 0) - (de ? 1 : 0);
      if (out_m > max_out) max_out = out_m;
      if (o_valid && rdy) chk("outstanding_over_max", (out_m > MAXO) ? out_m : 0, 0);
      prev_stall = o_valid && !rdy;
      prev_cmd = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n, input bit model);
    if (model) void'(build_model(n));
    nsamp = 12'(n);
    loaded = 1'b1;
    step();
    loaded = 1'b0;
  endtask

  task automatic finish_run(input string nm, input int c0, input int exp_cyc);
    int c;
    c = c0;
    while (!o_end && c < 20000) begin
      step();
      c++;
    end
    chk({nm, "_calc_end"}, o_end, 1);
    if (exp_cyc >= 0) chk({nm, "_cycles"}, c, exp_cyc);
    chk({nm, "_owner"}, o_owner, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_cmds_left"}, exp_q.size(), 0);
    chk({nm, "_outstanding"}, out_m, 0);
  endtask

  task automatic read_result(input string nm);
    rread = 1'b1;
    step();
    rread = 1'b0;
    chk({nm, "_end_cleared"}, o_end, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_a"}, o_a, 0);
    chk({nm, "_b"}, o_b, 0);
    chk({nm, "_tw"}, o_tw, 0);
    chk({nm, "_stage"}, o_stage, 0);
    chk({nm, "_owner"}, o_owner, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_end"}, o_end, 0);
    chk({nm, "_err"}, o_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; loaded = 1'b0; rread = 1'b0; nsamp = '0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // N=8, full-rate acceptance: 12 transfers, 2 + 3*(4+2) cycles to CALC_END
    void'(build_model(8));
    chk("model_n8_size", exp_q.size(), 12);
    chk("model_n8_k5_a", exp_q[5].a, 1);
    chk("model_n8_k5_b", exp_q[5].b, 3);
    chk("model_n8_k5_tw", exp_q[5].tw, 2);
    chk("model_n8_k11_b", exp_q[11].b, 7);
    chk("model_n8_k11_tw", exp_q[11].tw, 3);
    start(8, 0);
    chk("n8_check_busy", o_busy, 0);
    step();
    chk("n8_t1_busy", o_busy, 1);
    chk("n8_t1_owner", o_owner, 0);
    chk("n8_t1_valid", o_valid, 0);
    step();
    chk("n8_t2_valid", o_valid, 1);
    chk("n8_t2_owner", o_owner, 1);
    chk("n8_t2_a", o_a, 0);
    chk("n8_t2_b", o_b, 1);
    finish_run("n8", 2, 20);
    read_result("n8");

    // invalid sizes: 12, 0, 4096 (wraps to 0)
    start(12, 1); step(); step(); step();
    chk("n12_err", o_err, 1); chk("n12_owner", o_owner, 0); chk("n12_busy", o_busy, 0);
    start(0, 1); step(); step(); step();
    chk("n0_err", o_err, 1); chk("n0_owner", o_owner, 0);
    start(4096, 1); step(); step(); step();
    chk("n4096_err", o_err, 1); chk("n4096_owner", o_owner, 0); chk("n4096_valid", o_valid, 0);

    start(4, 1);
    step();
    chk("n4_err_cleared", o_err, 0);
    finish_run("n4", 1, 10);
    read_result("n4");

    start(2, 1);
    finish_run("n2", 0, 5);
    read_result("n2");

    // outstanding cap reached deterministically
    dly = 6; max_out = 0;
    start(16, 1);
    finish_run("n16_cap", 0, -1);
    chk("n16_cap_max_out", max_out, MAXO);
    read_result("n16_cap");

    // backpressure: random READY, DONE 10 cycles late
    dly = 10; rdy_mode = 1;
    start(16, 1);
    finish_run("n16_bp", 0, -1);
    read_result("n16_bp");
    dly = 1; rdy_mode = 0;

    // DATA_LOADED during ISSUE is ignored; in DONE it restarts directly
    start(8, 1);
    repeat (5) step();
    start(2, 0);
    chk("ignored_busy", o_busy, 1);
    finish_run("n8_ignore", 6, 20);
    start(8, 1);
    chk("restart_end_cleared", o_end, 0);
    finish_run("n8_restart", 0, 20);
    read_result("n8_restart");

    // asynchronous reset mid-stage 1 with 3 outstanding
    dly = 3;
    start(64, 1);
    c = 0;
    while (!(o_stage == 4'd1 && out_m == 3) && c < 5000) begin
      step();
      c++;
    end
    chk("rst_setup_outstanding", out_m, 3);
    chk("rst_setup_stage", o_stage, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    step();
    rst = 1'b0;
    dly = 1;
    start(64, 1);
    step(); step();
    chk("n64_first_stage", o_stage, 0);
    chk("n64_first_a", o_a, 0);
    chk("n64_first_b", o_b, 1);
    finish_run("n64", 2, 206);
    read_result("n64");

    void'(build_model(2048));
    chk("model_n2048_size", exp_q.size(), 11264);
    chk("model_n2048_last_tw", exp_q[exp_q.size()-1].tw, 1023);
    chk("model_n2048_last_b", exp_q[exp_q.size()-1].b, 2047);
    start(2048, 0);
    finish_run("n2048", 0, 11288);
    read_result("n2048");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
